// File: rtl/mdu_hilo.sv
// mdu_hilo: EX-stage multiply/divide unit with the architectural HI/LO pair.
// Multiplies take MUL_LAT cycles; divides take DIV_ITER restoring iterations
// plus one sign-fixup cycle. Optional MADD/MSUB is enabled by the
// MDU_MADD_EN macro. Without it, ops 110/111 are no-ops.
//
// Ports:
//   clk     core clock, rising edge
//   rst_n   synchronous active-low reset
//   start   request valid this cycle
//   op      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//           110 MADD, 111 MSUB
//   a, b    rs / rt operands, already forwarded
//   cancel  flush; aborts any in-flight operation
//   rd_sel  0 = read LO, 1 = read HI
//   RHLOut  selected HI/LO value, combinational from the registers
//   busy    operation in flight (registered)
//   done    one-cycle pulse on the edge HI/LO take a mul/div result
module mdu_hilo #(
    parameter int unsigned MUL_LAT  = 2,
    parameter int unsigned DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        rd_sel,
    output logic [31:0] RHLOut,
    output logic        busy,
    output logic        done
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_t;
    acc_t r_acc;
`endif

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
    state_t r_state;

    logic [XLEN-1:0]   r_hi, r_lo;
    logic [2*XLEN-1:0] r_prod;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_quo, r_rem, r_dvs;
    logic              r_q_neg, r_r_neg, r_dz;

    logic              w_accept;
    logic              w_mul_signed, w_a_neg, w_b_neg;
    logic [2*XLEN-1:0] w_a_ext, w_b_ext, w_prod;
    logic [XLEN-1:0]   w_dvd, w_dvs;
    logic [XLEN:0]     w_shift, w_trial;
    logic [XLEN-1:0]   w_quo_fix, w_rem_fix;

    assign RHLOut   = rd_sel ? r_hi : r_lo;
    assign w_accept = start && !cancel && (r_state == S_IDLE);

    // One 64-bit multiplier; sign/zero extension selects signed vs unsigned.
    assign w_mul_signed = (op != OP_MULTU);
    assign w_a_ext = w_mul_signed ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    assign w_b_ext = w_mul_signed ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Division runs on magnitudes; signs are reapplied in FIX.
    assign w_a_neg = (op == OP_DIV) && a[XLEN-1];
    assign w_b_neg = (op == OP_DIV) && b[XLEN-1];
    assign w_dvd   = w_a_neg ? (~a + 32'd1) : a;
    assign w_dvs   = w_b_neg ? (~b + 32'd1) : b;

    // Restoring step: shift next dividend bit into the partial remainder.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};

    assign w_quo_fix = r_q_neg ? (~r_quo + 32'd1) : r_quo;
    assign w_rem_fix = r_r_neg ? (~r_rem + 32'd1) : r_rem;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_dz    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef MDU_MADD_EN
            r_acc   <= ACC_NONE;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                r_prod  <= w_prod;
                                r_cnt   <= CNT_W'(MUL_LAT - 1);
                                busy    <= 1'b1;
                                r_state <= S_MUL;
`ifdef MDU_MADD_EN
                                r_acc   <= ACC_NONE;
`endif
                            end
`ifdef MDU_MADD_EN
                            OP_MADD, OP_MSUB: begin
                                r_prod  <= w_prod;
                                r_cnt   <= CNT_W'(MUL_LAT - 1);
                                busy    <= 1'b1;
                                r_state <= S_MUL;
                                r_acc   <= (op == OP_MADD) ? ACC_ADD : ACC_SUB;
                            end
`endif
                            OP_DIV, OP_DIVU: begin
                                r_quo   <= w_dvd;
                                r_rem   <= '0;
                                r_dvs   <= w_dvs;
                                r_q_neg <= w_a_neg ^ w_b_neg;
                                r_r_neg <= w_a_neg;
                                r_dz    <= (b == '0);
                                r_cnt   <= CNT_W'(DIV_ITER - 1);
                                busy    <= 1'b1;
                                r_state <= S_DIV;
                            end
                            OP_MTHI: r_hi <= a;
                            OP_MTLO: r_lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cancel) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_cnt == '0) begin
`ifdef MDU_MADD_EN
                        // Accumulate against HI/LO as they stand at this edge.
                        case (r_acc)
                            ACC_ADD: {r_hi, r_lo} <= {r_hi, r_lo} + r_prod;
                            ACC_SUB: {r_hi, r_lo} <= {r_hi, r_lo} - r_prod;
                            default: {r_hi, r_lo} <= r_prod;
                        endcase
`else
                        {r_hi, r_lo} <= r_prod;
`endif
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DIV: begin
                    if (cancel) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        if (!w_trial[XLEN]) begin
                            r_rem <= w_trial[XLEN-1:0];
                            r_quo <= {r_quo[XLEN-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[XLEN-1:0];
                            r_quo <= {r_quo[XLEN-2:0], 1'b0};
                        end
                        if (r_cnt == '0) r_state <= S_FIX;
                        else             r_cnt   <= r_cnt - CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (cancel) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        // Divide by zero: quotient all ones, remainder = a.
                        r_lo    <= r_dz ? '1 : w_quo_fix;
                        r_hi    <= w_rem_fix;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit and architectural HI/LO register pair for the MIPS core.
- Sits in the EX stage. Operands come from the RS/RT forwarding-mux outputs.
- Its read port drives the RHLOut input of the writeback-data select (MFHI/MFLO path).
- Multiplies and divides are multi-cycle. `busy` feeds the hazard unit, which stalls MDU-dependent instructions.

Parameters:
- MUL_LAT, 2, cycles from an accepted multiply to HI/LO update (legal range 1..4).
- DIV_ITER, 32, restoring-division iterations; fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  issue a request this cycle (EX-stage MDU instruction valid).
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
- a  in  32  rs operand, already forwarded.
- b  in  32  rt operand, already forwarded.
- cancel  in  1  flush from exception/eret; aborts any in-flight operation.
- rd_sel  in  1  0 = read LO, 1 = read HI.
- RHLOut  out  32  selected HI/LO value; combinational from the registers.
- busy  out  1  operation in flight; new start is not accepted.
- done  out  1  one-cycle pulse on the edge HI/LO take a multiply/divide result.

Behaviour:
- Reset (rst_n=0 at an edge): HI=0, LO=0, busy=0, done=0, state=IDLE, counters cleared. Reset dominates all other inputs, including mid-operation.
- States: IDLE, MUL, DIV, FIX.
- Accept rule: start is accepted only when state=IDLE and cancel=0.
  - start while busy=1 is ignored; the hazard unit guarantees none is issued.
  - start with cancel=1 is ignored.
- MTHI/MTLO:
  - Write a into HI/LO at the accept edge.
  - No busy, no done.
  - RHLOut shows the new value from the following cycle.
- MULT/MULTU:
  - 64-bit product, signed or unsigned, latched at accept.
  - State MUL for MUL_LAT cycles.
  - On the last edge: HI=prod[63:32], LO=prod[31:0], done=1 for 1 cycle, return to IDLE.
  - busy is high for exactly MUL_LAT cycles after the accept edge.
- DIV/DIVU:
  - At accept, latch |a| and |b| (DIV) or raw a and b (DIVU), plus the sign flags.
  - Enter DIV: 32 restoring iterations, 1 per cycle.
  - Then FIX, 1 cycle, applies signs:
    - quotient negated if sign(a)≠sign(b);
    - remainder takes the sign of a.
  - On the FIX edge: LO=quotient, HI=remainder, done=1.
  - busy is high for 33 cycles after the accept edge.
  - 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0.
- Divide by zero (b=0), both signednesses:
  - Full 33-cycle latency.
  - LO=0xFFFFFFFF, HI=a.
  - done asserted as normal.
- Cancel while busy:
  - Next edge: state=IDLE, busy=0.
  - HI/LO unchanged, no done pulse.
  - cancel in IDLE has no effect.
- RHLOut = rd_sel ? HI : LO at all times.
  - Results written at an edge are visible the following cycle.
  - No internal bypass; forwarding of in-flight MDU results is external.
- done and busy are never both 1 in the same cycle as a new accept.
- done cycle: busy=0.
- Back-to-back issue: a start in the cycle where done=1 is accepted.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - op 110 (MADD) computes {HI,LO} + signed a*b.
  - op 111 (MSUB) computes {HI,LO} − signed a*b.
  - The accumulate happens in the final MUL cycle against the HI/LO values current at that edge.
  - Latency is MUL_LAT, identical to MULT.
- Undefined:
  - ops 110/111 are treated as no-ops: nothing is written, busy stays 0, no done.
  - The accumulate adder is absent.

Test Plan:
- Reset: hold rst_n=0 2 cycles mid-divide → HI=LO=0, busy=0, done=0; RHLOut=0 for both rd_sel values.
- MULT a=0xFFFFFFFE (−2), b=3 → busy 2 cycles, done pulse; HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU on the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (−7), b=2 → busy 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU a=0x12345678, b=0 → after 33 cycles LO=0xFFFFFFFF, HI=0x12345678.
- MTHI a=0xDEADBEEF, then DIV started, then cancel at cycle 10 → busy drops next cycle, no done; HI remains 0xDEADBEEF; a start in the same cycle as cancel is ignored.
- MDU_MADD_EN: HI/LO=0x00000000_00000005, MADD a=3, b=4 → LO=0x11, HI=0; then MSUB a=1, b=0x20 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Without the macro, the same sequence leaves HI/LO unchanged and busy never rises.
